// File: rtl/sleep_timer_bank.sv
// Bank of independent programmable timer / clock-divider channels.
// Each channel runs one-shot or periodic and exposes a divided clock, a terminal tick and status.
module sleep_timer_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned DEFAULT_DIV = 150150150,
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                inclok,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] outclok,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q   [CHANNELS];
  state_e            state_d   [CHANNELS];
  logic [WIDTH-1:0]  cnt_q     [CHANNELS];
  logic [WIDTH-1:0]  cnt_d     [CHANNELS];
  logic [WIDTH-1:0]  act_div_q [CHANNELS];
  logic [WIDTH-1:0]  act_div_d [CHANNELS];
  logic [WIDTH-1:0]  div_q     [CHANNELS];
  logic [WIDTH-1:0]  div_d     [CHANNELS];
  logic              mode_q    [CHANNELS];
  logic              mode_d    [CHANNELS];
  logic              act_mode_q[CHANNELS];
  logic              act_mode_d[CHANNELS];

  logic [CHANNELS-1:0] outclok_d, tick_d, busy_d, done_d;
  logic [WIDTH-1:0]    cfg_div_clamped;
  logic                wr_hit;

  assign cfg_div_clamped = (cfg_div < WIDTH'(2)) ? WIDTH'(2) : cfg_div;

  always_comb begin
    outclok_d = '0;
    tick_d    = '0;
    busy_d    = '0;
    done_d    = '0;
    wr_hit    = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      act_div_d[i]  = act_div_q[i];
      act_mode_d[i] = act_mode_q[i];
      div_d[i]      = div_q[i];
      mode_d[i]     = mode_q[i];

      // Out-of-range cfg_ch never equals a valid index, so such writes fall through.
      wr_hit = cfg_we && (cfg_ch == CH_W'(i));
      if (wr_hit) begin
        div_d[i]  = cfg_div_clamped;
        mode_d[i] = cfg_mode;
      end

      if (stop[i]) begin
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
      end else if (start[i]) begin
        state_d[i]    = StRun;
        cnt_d[i]      = '0;
        act_div_d[i]  = div_d[i];
        act_mode_d[i] = mode_d[i];
      end else if (state_q[i] == StRun) begin
        if (cnt_q[i] == act_div_q[i] - WIDTH'(1)) begin
          cnt_d[i] = '0;
          if (act_mode_q[i]) begin
            act_div_d[i] = div_q[i];
          end else begin
            state_d[i] = StDone;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end

      // Outputs are registered copies of the decode of next state.
      busy_d[i]    = (state_d[i] == StRun);
      done_d[i]    = (state_d[i] == StDone);
      tick_d[i]    = busy_d[i] && (cnt_d[i] == act_div_d[i] - WIDTH'(1));
      outclok_d[i] = busy_d[i] && (cnt_d[i] >= (act_div_d[i] >> 1));
    end
  end

  always_ff @(posedge inclok or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i]    <= StIdle;
        cnt_q[i]      <= '0;
        act_div_q[i]  <= WIDTH'(DEFAULT_DIV);
        act_mode_q[i] <= 1'b0;
        div_q[i]      <= WIDTH'(DEFAULT_DIV);
        mode_q[i]     <= 1'b0;
      end
      outclok <= '0;
      tick    <= '0;
      busy    <= '0;
      done    <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i]    <= state_d[i];
        cnt_q[i]      <= cnt_d[i];
        act_div_q[i]  <= act_div_d[i];
        act_mode_q[i] <= act_mode_d[i];
        div_q[i]      <= div_d[i];
        mode_q[i]     <= mode_d[i];
      end
      outclok <= outclok_d;
      tick    <= tick_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_sleep_timer_bank.sv
// Self-checking bench for sleep_timer_bank: directed scenarios plus random traffic against a
// timestamp-based reference model (each period is described by its start cycle and length).
module tb_sleep_timer_bank;

  localparam int unsigned NCH  = 4;
  localparam int unsigned W    = 28;
  localparam int unsigned DDIV = 150150150;

  logic           inclok = 1'b0;
  logic           rst_n  = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [W-1:0]   cfg_div = '0;
  logic           cfg_mode = 1'b0;
  logic [NCH-1:0] start = '0;
  logic [NCH-1:0] stop = '0;
  logic [NCH-1:0] outclok, tick, busy, done;

  sleep_timer_bank #(
    .CHANNELS   (NCH),
    .WIDTH      (W),
    .DEFAULT_DIV(DDIV)
  ) dut (
    .inclok  (inclok),
    .rst_n   (rst_n),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_mode(cfg_mode),
    .start   (start),
    .stop    (stop),
    .outclok (outclok),
    .tick    (tick),
    .busy    (busy),
    .done    (done)
  );

  always #5 inclok = ~inclok;

  int    n_checks = 0;
  int    n_errors = 0;
  longint cyc = 0;

  // Reference model: a running channel's current period began at p_start and lasts m_d cycles.
  bit     m_run   [NCH];
  bit     m_done  [NCH];
  bit     m_per   [NCH];
  int     m_d     [NCH];
  longint m_start [NCH];
  int     m_divr  [NCH];
  bit     m_moder [NCH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_done[c] = 0; m_per[c] = 0; m_d[c] = DDIV;
      m_start[c] = 0; m_divr[c] = DDIV; m_moder[c] = 0;
    end
  endtask

  task automatic model_step(input bit we, input int ch, input int dv, input bit md,
                            input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    int nd;
    nd = (dv < 2) ? 2 : dv;
    for (int c = 0; c < NCH; c++) begin
      bit wr;
      wr = we && (ch == c);
      if (sp[c]) begin
        m_run[c] = 0; m_done[c] = 0;
      end else if (st[c]) begin
        m_run[c] = 1; m_done[c] = 0; m_start[c] = cyc;
        m_d[c]   = wr ? nd : m_divr[c];
        m_per[c] = wr ? md : m_moder[c];
      end else if (m_run[c] && (cyc - 1 - m_start[c]) == longint'(m_d[c] - 1)) begin
        if (m_per[c]) begin
          m_start[c] = cyc; m_d[c] = m_divr[c];
        end else begin
          m_run[c] = 0; m_done[c] = 1;
        end
      end
      if (wr) begin
        m_divr[c] = nd; m_moder[c] = md;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] e_busy, e_done, e_tick, e_clk;
    for (int c = 0; c < NCH; c++) begin
      longint pos;
      pos = cyc - m_start[c];
      e_busy[c] = m_run[c];
      e_done[c] = m_done[c];
      e_tick[c] = m_run[c] && (pos == longint'(m_d[c] - 1));
      e_clk[c]  = m_run[c] && (pos >= longint'(m_d[c] / 2));
    end
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("tick", 32'(tick), 32'(e_tick));
    check_eq("outclok", 32'(outclok), 32'(e_clk));
  endtask

  // Drive one cycle's inputs, let the edge happen, advance the model and compare.
  task automatic cyc_step(input bit we, input int ch, input int dv, input bit md,
                          input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    cfg_we = we; cfg_ch = ch[1:0]; cfg_div = dv[W-1:0]; cfg_mode = md;
    start = st; stop = sp;
    @(posedge inclok);
    cyc++;
    model_step(we, ch, dv, md, st, sp);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_step(0, 0, 0, 0, '0, '0);
  endtask

  task automatic pulse_reset();
    cfg_we = 0; start = '0; stop = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_all_zero", 32'({outclok, tick, busy, done}), 32'h0);
    @(posedge inclok);
    #1;
    check_eq("rst_held_zero", 32'({outclok, tick, busy, done}), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    int pat[5];
    pat = '{0, 0, 1, 1, 1};
    model_reset();

    // Reset values and quiet idle.
    #2;
    check_eq("por_zero", 32'({outclok, tick, busy, done}), 32'h0);
    @(posedge inclok);
    #1;
    check_eq("por_held", 32'({outclok, tick, busy, done}), 32'h0);
    rst_n = 1'b1;
    idle(100);

    // Ch0 one-shot D=4.
    cyc_step(1, 0, 4, 0, '0, '0);
    cyc_step(0, 0, 0, 0, 4'b0001, '0);
    check_eq("os_busy_k", 32'(busy[0]), 32'd1);
    idle(2);
    check_eq("os_tick_pre", 32'(tick[0]), 32'd0);
    idle(1);
    check_eq("os_tick", 32'(tick[0]), 32'd1);
    idle(1);
    check_eq("os_done", 32'(done[0]), 32'd1);
    check_eq("os_busy_off", 32'(busy[0]), 32'd0);
    idle(5);
    check_eq("os_done_sticky", 32'(done[0]), 32'd1);

    // Ch1 periodic D=5, then retune to 3 mid-run.
    cyc_step(1, 1, 5, 1, '0, '0);
    cyc_step(0, 0, 0, 0, 4'b0010, '0);
    for (int i = 1; i < 11; i++) begin
      cyc_step(0, 0, 0, 0, '0, '0);
      check_eq("per5_outclok", 32'(outclok[1]), 32'(pat[i % 5]));
    end
    cyc_step(1, 1, 3, 1, '0, '0);
    idle(15);

    // Ch2: stop+start while running, then restart alone.
    cyc_step(1, 2, 6, 1, 4'b0100, '0);
    idle(3);
    cyc_step(0, 0, 0, 0, 4'b0100, 4'b0100);
    check_eq("stop_wins_busy", 32'(busy[2]), 32'd0);
    check_eq("stop_wins_out", 32'({outclok[2], tick[2], done[2]}), 32'd0);
    cyc_step(0, 0, 0, 0, 4'b0100, '0);
    idle(3);
    cyc_step(0, 0, 0, 0, 4'b0100, '0);
    idle(8);

    // Clamping of divisors 0 and 1 on ch3.
    cyc_step(1, 3, 0, 1, '0, '0);
    cyc_step(0, 0, 0, 0, 4'b1000, '0);
    idle(6);
    cyc_step(1, 3, 1, 1, 4'b1000, '0);
    idle(6);

    // All channels concurrently, reset mid-run, restart.
    stop = '1;
    cyc_step(0, 0, 0, 0, '0, 4'b1111);
    for (int c = 0; c < NCH; c++) cyc_step(1, c, 3 + c, 1, '0, '0);
    cyc_step(0, 0, 0, 0, 4'b1111, '0);
    idle(10);
    pulse_reset();
    for (int c = 0; c < NCH; c++) cyc_step(1, c, 3 + c, 1, '0, '0);
    cyc_step(0, 0, 0, 0, 4'b1111, '0);
    idle(30);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [NCH-1:0] st, sp;
      for (int c = 0; c < NCH; c++) begin
        st[c] = ($urandom_range(0, 19) == 0);
        sp[c] = ($urandom_range(0, 39) == 0);
      end
      cyc_step(($urandom_range(0, 3) == 0), $urandom_range(0, NCH - 1), $urandom_range(0, 9),
               $urandom_range(0, 1), st, sp);
      if (i == 1500) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
